// File: rtl/bcd_serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// bcd_serial_subtractor_if
//   Request/result bundle for the digit-serial packed-BCD subtractor.
//   master : the requester (drives start and the operands, observes results)
//   slave  : the subtractor (observes the request, drives status and results)
// Signals
//   start       request, sampled by the subtractor only while it is idle
//   minuend     packed BCD, digit 0 in bits [3:0]
//   subtrahend  packed BCD, same packing
//   busy        high while digits are being processed
//   done        one-cycle pulse marking diff/borrow/invalid as valid
//   diff        packed BCD difference (ten's complement when borrow=1)
//   borrow      borrow out of the most significant digit
//   invalid     some operand nibble of the accepted request was above 9
// ---------------------------------------------------------------------------
interface bcd_serial_subtractor_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   minuend;
  logic [4*DIGITS-1:0]   subtrahend;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  borrow;
  logic                  invalid;

  modport master (
    output start, minuend, subtrahend,
    input  busy, done, diff, borrow, invalid
  );

  modport slave (
    input  start, minuend, subtrahend,
    output busy, done, diff, borrow, invalid
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// ---------------------------------------------------------------------------
// bcd_serial_subtractor
//   Digit-serial packed-BCD subtractor computing minuend - subtrahend one
//   decimal digit per clock, least significant digit first. The inter-digit
//   borrow lives in a register so each cycle only needs a single 4-bit
//   decimal subtract stage.
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset (aborts any operation in flight)
//   bus   slave side of bcd_serial_subtractor_if (start/operands in,
//         busy/done/diff/borrow/invalid out, all outputs registered)
// ---------------------------------------------------------------------------
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_serial_subtractor_if.slave  bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True when every nibble of a packed operand is a legal decimal digit.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (v[4*j +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  state_t           state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic             br_q,      br_d;
  logic [W-1:0]     a_q,       a_d;
  logic [W-1:0]     b_q,       b_d;
  logic [W-1:0]     diff_q,    diff_d;
  logic             borrow_q,  borrow_d;
  logic             invalid_q, invalid_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  // Digit datapath signals for the digit selected by idx_q.
  logic [3:0]       a_dig;
  logic [3:0]       b_dig;
  logic [4:0]       t;       // two's complement, range -10..9
  logic [3:0]       d_dig;
  logic             br_out;

  // Select the current digit pair and perform one decimal subtract step.
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int j = 0; j < DIGITS; j++) begin
      if (idx_q == IDX_W'(j)) begin
        a_dig = a_q[4*j +: 4];
        b_dig = b_q[4*j +: 4];
      end else begin
        a_dig = a_dig;
        b_dig = b_dig;
      end
    end
    t = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, br_q};
    // Negative partial result: add ten (mod 16 on the low nibble gives the
    // correct decimal digit) and borrow from the next digit.
    if (t[4]) begin
      d_dig  = t[3:0] + 4'd10;
      br_out = 1'b1;
    end else begin
      d_dig  = t[3:0];
      br_out = 1'b0;
    end
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    br_d      = br_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    invalid_d = invalid_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.minuend;
          b_d   = bus.subtrahend;
          idx_d = IDX_W'(0);
          br_d  = 1'b0;
          if (bcd_valid(bus.minuend) && bcd_valid(bus.subtrahend)) begin
            // diff/borrow keep their old values until digits are written.
            invalid_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = S_RUN;
          end else begin
            diff_d    = '0;
            borrow_d  = 1'b0;
            invalid_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        for (int j = 0; j < DIGITS; j++) begin
          if (idx_q == IDX_W'(j)) begin
            diff_d[4*j +: 4] = d_dig;
          end else begin
            diff_d[4*j +: 4] = diff_q[4*j +: 4];
          end
        end
        br_d = br_out;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          borrow_d = br_out;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and aborts any op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      br_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      br_q      <= br_d;
      a_q       <= a_d;
      b_q       <= b_d;
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.diff    = diff_q;
  assign bus.borrow  = borrow_q;
  assign bus.invalid = invalid_q;

endmodule
